// File: rtl/mips_fetch_unit_pkg.sv
// Shared definitions for the MIPS fetch stage: FSM encoding, reset constants
// and opcode field location.
package mips_fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;

    function automatic logic word_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/mips_pc_next.sv
// Combinational next-PC selection: jump over branch over sequential, with
// redirect targets forced to word alignment and a misalignment indication.
module mips_pc_next
    import mips_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misalign
);

    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] raw_target;
    logic              redirect;

    always_comb begin
        // Jump keeps the segment bits of the sequential address.
        jump_target        = pc_plus4;
        jump_target[27:0]  = {jump_index, 2'b00};

        raw_target = pc_plus4;
        redirect   = 1'b0;
        if (jump) begin
            raw_target = jump_target;
            redirect   = 1'b1;
        end else if (branch_taken) begin
            raw_target = branch_target;
            redirect   = 1'b1;
        end

        misalign = redirect && word_misaligned(raw_target[1:0]);
        next_pc  = {raw_target[ADDR_W-1:2], 2'b00};
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request, instruction
// register and handoff to decode with jump/branch redirect.
module mips_fetch_unit
    import mips_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    output logic              misalign_err
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] next_pc;
    logic              next_misalign;

    assign pc_plus4    = pc + ADDR_W'(4);
    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == VALID);
    assign opcode      = instr[OPCODE_MSB:OPCODE_LSB];

    mips_pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc_plus4      (pc_plus4),
        .jump          (jump),
        .jump_index    (jump_index),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc),
        .misalign      (next_misalign)
    );

    // Redirect inputs and memory responses only matter in the states that
    // consume them; everywhere else they are dropped without buffering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            instr        <= NOP_INSTR;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem_rvalid) begin
                        instr <= imem_rdata;
                        state <= VALID;
                    end
                end
                VALID: begin
                    if (!stall) begin
                        pc           <= next_pc;
                        misalign_err <= misalign_err | next_misalign;
                        state        <= FETCH;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: wait-state memory model plus a queue of
// expected fetch addresses checked when each instruction reaches decode.
module tb_mips_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        misalign_err;

    int unsigned mem_wait;
    int unsigned wcnt;
    logic        stray;
    int          checks;
    int          failures;
    logic [31:0] sb[$];

    mips_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .misalign_err  (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[7:2] + 6'd1, a[25:0]} ^ 32'h0001_3C00;
    endfunction

    // Memory answers after mem_wait cycles of a held request; stray forces a
    // response with a poison word regardless of the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      wcnt <= 0;
        else if (imem_req && !imem_rvalid) wcnt <= wcnt + 1;
        else                             wcnt <= 0;
    end
    assign imem_rvalid = (imem_req && (wcnt >= mem_wait)) || stray;
    assign imem_rdata  = stray ? 32'hDEAD_BEEF : word_of(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] addr);
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, imem_addr, addr);
        chk({tag, "_nvalid"}, 32'(instr_valid), 32'd0);
        sb.push_back(addr);
    endtask

    task automatic expect_valid(input string tag);
        logic [31:0] a;
        logic [31:0] w;
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_noreq"}, 32'(imem_req), 32'd0);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb: observed=empty expected=pending fetch", tag);
        end else begin
            a = sb.pop_front();
            w = word_of(a);
            chk({tag, "_pc"}, pc, a);
            chk({tag, "_pc4"}, pc_plus4, a + 32'd4);
            chk({tag, "_instr"}, instr, w);
            chk({tag, "_opcode"}, {26'h0, opcode}, {26'h0, w[31:26]});
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_index = '0; mem_wait = 0; stray = 1'b0;

        // Reset state
        step(); step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_err", 32'(misalign_err), 32'd0);
        rst_n = 1'b1;

        // Zero-wait sequential fetch, valid every second cycle
        step(); expect_fetch("t1_f0", 32'h0);
        step(); expect_valid("t1_v0");
        step(); expect_fetch("t1_f1", 32'h4);
        step(); expect_valid("t1_v1");
        step(); expect_fetch("t1_f2", 32'h8);
        step(); expect_valid("t1_v2");
        mem_wait = 3;

        // Three wait cycles: address stable, instr updates only on rvalid
        step(); expect_fetch("t2_f", 32'hC);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_hold_req", 32'(imem_req), 32'd1);
            chk("t2_hold_addr", imem_addr, 32'hC);
            chk("t2_old_instr", instr, word_of(32'h8));
        end
        step(); expect_valid("t2_v");
        mem_wait = 0;

        // Stall with branch asserted and a stray response: nothing moves
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100; stray = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_valid", 32'(instr_valid), 32'd1);
            chk("t3_pc", pc, 32'hC);
            chk("t3_instr", instr, word_of(32'hC));
            chk("t3_req", 32'(imem_req), 32'd0);
        end
        stall = 1'b0; branch_taken = 1'b0; stray = 1'b0;
        step(); expect_fetch("t3_f", 32'h10);
        step(); expect_valid("t3_v");

        // Branch to 0x0040_0010, then jump+branch together: jump wins
        branch_taken = 1'b1; branch_target = 32'h0040_0010;
        step(); branch_taken = 1'b0; expect_fetch("t4_bf", 32'h0040_0010);
        step(); expect_valid("t4_bv");
        jump = 1'b1; jump_index = 26'h000_0100; branch_taken = 1'b1; branch_target = 32'h0040_0800;
        step(); jump = 1'b0; branch_taken = 1'b0; expect_fetch("t4_jf", 32'h0000_0400);
        chk("t4_err", 32'(misalign_err), 32'd0);
        step(); expect_valid("t4_jv");

        // Jump keeps the upper PC segment
        branch_taken = 1'b1; branch_target = 32'h3000_0000;
        step(); branch_taken = 1'b0; expect_fetch("t4_sf", 32'h3000_0000);
        step(); expect_valid("t4_sv");
        jump = 1'b1; jump_index = 26'h3FF_FFFF;
        step(); jump = 1'b0; expect_fetch("t4_uf", 32'h3FFF_FFFC);
        step(); expect_valid("t4_uv");

        // Misaligned branch target: aligned fetch, sticky error
        branch_taken = 1'b1; branch_target = 32'h0000_0102;
        step(); branch_taken = 1'b0; expect_fetch("t5_f", 32'h0000_0100);
        chk("t5_err_set", 32'(misalign_err), 32'd1);
        step(); expect_valid("t5_v");
        step(); expect_fetch("t5_f2", 32'h0000_0104);
        chk("t5_err_sticky", 32'(misalign_err), 32'd1);
        step(); expect_valid("t5_v2");

        // PC wrap from the top word
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        step(); branch_taken = 1'b0; expect_fetch("wrap_f", 32'hFFFF_FFFC);
        step(); expect_valid("wrap_v");
        step(); expect_fetch("wrap_f0", 32'h0);
        step(); expect_valid("wrap_v0");
        mem_wait = 3;

        // Reset mid-FETCH drops the request immediately
        step(); expect_fetch("t6_f", 32'h4);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_req_drop", 32'(imem_req), 32'd0);
        chk("t6_valid", 32'(instr_valid), 32'd0);
        chk("t6_pc", pc, 32'h0);
        chk("t6_instr", instr, 32'h0);
        chk("t6_err_clr", 32'(misalign_err), 32'd0);
        sb.delete();
        step();
        rst_n = 1'b1; mem_wait = 0; stray = 1'b1;
        step(); stray = 1'b0;
        chk("t6_boot_discard", instr, 32'h0);
        expect_fetch("t6_rf", 32'h0);
        step(); expect_valid("t6_rv");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
